// File: rtl/chunk_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock.
// A registered carry ripples between chunks, and valid/ready handshakes are used on both sides.
module chunk_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out,
    output logic             Overflow
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NCH-1:0]   chunk_hit;
    logic [CHUNK-1:0] a_sel, b_sel;
    logic [CHUNK:0]   csum;

    // One-hot decode of the active chunk index drives the operand mux and the Sum write enable.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_hit
            assign chunk_hit[gi] = (k_q == KW'(gi));
        end
    endgenerate

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chunk_hit[i]) begin
                a_sel = opa_q[i*CHUNK +: CHUNK];
                b_sel = opb_q[i*CHUNK +: CHUNK];
            end
        end
        csum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d   = A;
                    opb_d   = Sub ? ~B : B;
                    carry_d = C_in ^ Sub;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NCH; i++) begin
                    if (chunk_hit[i]) begin
                        sum_d[i*CHUNK +: CHUNK] = csum[CHUNK-1:0];
                    end
                end
                carry_d = csum[CHUNK];
                k_d     = k_q + KW'(1);
                if (chunk_hit[NCH-1]) begin
                    // The top chunk's MSB is the result sign bit; opb_q is already inverted for subtraction.
                    cout_d  = csum[CHUNK];
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (csum[CHUNK-1] != opa_q[WIDTH-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Sum       = sum_q;
    assign C_out     = cout_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed and randomised checks of chunk_serial_adder for CHUNK=2 (main), CHUNK=8 and CHUNK=1.
module tb_chunk_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_i, b_i;
    logic       cin_i, sub_i;
    logic       iv_m, or_m, iv_s;
    logic       or_s = 1'b1;

    logic       ir_m, ov_m, co_m, of_m;
    logic [7:0] sum_m;
    logic       ir_8, ov_8, co_8, of_8;
    logic [7:0] sum_8;
    logic       ir_1, ov_1, co_1, of_1;
    logic [7:0] sum_1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_m), .in_ready(ir_m),
        .A(a_i), .B(b_i), .C_in(cin_i), .Sub(sub_i),
        .out_valid(ov_m), .out_ready(or_m), .Sum(sum_m), .C_out(co_m), .Overflow(of_m)
    );

    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut_8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_8),
        .A(a_i), .B(b_i), .C_in(cin_i), .Sub(sub_i),
        .out_valid(ov_8), .out_ready(or_s), .Sum(sum_8), .C_out(co_8), .Overflow(of_8)
    );

    chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_1),
        .A(a_i), .B(b_i), .C_in(cin_i), .Sub(sub_i),
        .out_valid(ov_1), .out_ready(or_s), .Sum(sum_1), .C_out(co_1), .Overflow(of_1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic reference: A+B+cin, or A-B-cin with carry meaning "no borrow".
    task automatic ref_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                          output logic [7:0] s, output logic co, output logic of);
        int ia, ib, ci, sa, sb, r, sr;
        ia = int'(a);
        ib = int'(b);
        ci = int'(cin);
        sa = $signed(a);
        sb = $signed(b);
        if (!sub) begin
            r  = ia + ib + ci;
            co = (r > 255);
            sr = sa + sb + ci;
        end else begin
            r  = ia - ib - ci;
            co = (ia >= ib + ci);
            sr = sa - sb - ci;
        end
        s  = r[7:0];
        of = (sr > 127) || (sr < -128);
    endtask

    task automatic accept_m(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        a_i = a; b_i = b; cin_i = cin; sub_i = sub; iv_m = 1'b1;
        chk("m_in_ready_idle", 32'(ir_m), 32'd1);
        tick;
        iv_m  = 1'b0;
        a_i   = 8'($urandom);
        b_i   = 8'($urandom);
        cin_i = 1'($urandom);
        sub_i = 1'($urandom);
        chk("m_in_ready_run", 32'(ir_m), 32'd0);
    endtask

    task automatic wait_m(input string tag, input logic [7:0] es, input logic eco, input logic eof);
        int n = 0;
        while (ov_m !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_sum"}, 32'(sum_m), 32'(es));
        chk({tag, "_cout"}, 32'(co_m), 32'(eco));
        chk({tag, "_ovf"}, 32'(of_m), 32'(eof));
        $display("op %s: lat=%0d Sum=%02h C_out=%0b Overflow=%0b", tag, n, sum_m, co_m, of_m);
    endtask

    task automatic release_m(input string tag);
        or_m = 1'b1;
        tick;
        chk({tag, "_ov_drop"}, 32'(ov_m), 32'd0);
        chk({tag, "_ready_rise"}, 32'(ir_m), 32'd1);
    endtask

    task automatic run_s(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        logic [7:0] es;
        logic eco, eof;
        int n = 0;
        int l8 = -1;
        int l1 = -1;
        ref_op(a, b, cin, sub, es, eco, eof);
        a_i = a; b_i = b; cin_i = cin; sub_i = sub; iv_s = 1'b1;
        chk("s8_in_ready", 32'(ir_8), 32'd1);
        chk("s1_in_ready", 32'(ir_1), 32'd1);
        tick;
        iv_s  = 1'b0;
        a_i   = 8'($urandom);
        b_i   = 8'($urandom);
        cin_i = 1'($urandom);
        sub_i = 1'($urandom);
        while ((l8 < 0 || l1 < 0) && n < 20) begin
            tick;
            n++;
            if (ov_8 === 1'b1 && l8 < 0) begin
                l8 = n;
                chk("s8_sum", 32'(sum_8), 32'(es));
                chk("s8_cout", 32'(co_8), 32'(eco));
                chk("s8_ovf", 32'(of_8), 32'(eof));
            end
            if (ov_1 === 1'b1 && l1 < 0) begin
                l1 = n;
                chk("s1_sum", 32'(sum_1), 32'(es));
                chk("s1_cout", 32'(co_1), 32'(eco));
                chk("s1_ovf", 32'(of_1), 32'(eof));
            end
        end
        chk("s8_latency", 32'(l8), 32'd1);
        chk("s1_latency", 32'(l1), 32'd8);
        $display("sweep A=%02h B=%02h Cin=%0b Sub=%0b: lat8=%0d lat1=%0d Sum=%02h/%02h", a, b, cin, sub, l8, l1, sum_8, sum_1);
        tick;
        chk("s1_back_idle", 32'(ir_1), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, es;
        logic rc, rs, eco, eof;

        rst_n = 1'b0; iv_m = 1'b0; iv_s = 1'b0; or_m = 1'b1;
        a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0; sub_i = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(ir_m), 32'd1);
        chk("rst_out_valid", 32'(ov_m), 32'd0);
        chk("rst_sum", 32'(sum_m), 32'd0);
        chk("rst_cout", 32'(co_m), 32'd0);
        chk("rst_ovf", 32'(of_m), 32'd0);

        accept_m(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_m("add_5a_3c", 8'h96, 1'b0, 1'b1);
        release_m("add_5a_3c");

        accept_m(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_m("wrap_c0", 8'h00, 1'b1, 1'b0);
        release_m("wrap_c0");
        accept_m(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_m("wrap_c1", 8'h01, 1'b1, 1'b0);
        release_m("wrap_c1");

        accept_m(8'h10, 8'h20, 1'b0, 1'b1);
        wait_m("sub_10_20", 8'hF0, 1'b0, 1'b0);
        release_m("sub_10_20");
        accept_m(8'h80, 8'h01, 1'b0, 1'b1);
        wait_m("sub_80_01", 8'h7F, 1'b1, 1'b1);
        release_m("sub_80_01");
        accept_m(8'h05, 8'h05, 1'b1, 1'b1);
        wait_m("sub_05_05_b", 8'hFF, 1'b0, 1'b0);
        release_m("sub_05_05_b");

        // Backpressure: result must hold and no new operand may be taken while DONE.
        accept_m(8'h33, 8'h11, 1'b0, 1'b0);
        or_m = 1'b0;
        wait_m("bp_first", 8'h44, 1'b0, 1'b0);
        a_i = 8'h70; b_i = 8'h10; cin_i = 1'b0; sub_i = 1'b0; iv_m = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_out_valid", 32'(ov_m), 32'd1);
            chk("bp_in_ready", 32'(ir_m), 32'd0);
            chk("bp_sum_hold", 32'(sum_m), 32'h44);
            chk("bp_cout_hold", 32'(co_m), 32'd0);
            chk("bp_ovf_hold", 32'(of_m), 32'd0);
        end
        release_m("bp_release");
        accept_m(8'h70, 8'h10, 1'b0, 1'b0);
        wait_m("bp_second", 8'h80, 1'b0, 1'b1);
        release_m("bp_second");

        // Reset while the chunk index is 2 aborts the operation.
        accept_m(8'hAA, 8'h55, 1'b0, 1'b0);
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midrst_sum", 32'(sum_m), 32'd0);
        chk("midrst_cout", 32'(co_m), 32'd0);
        chk("midrst_ovf", 32'(of_m), 32'd0);
        chk("midrst_out_valid", 32'(ov_m), 32'd0);
        chk("midrst_in_ready", 32'(ir_m), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("midrst_no_result", 32'(ov_m), 32'd0);
        end
        accept_m(8'h01, 8'h01, 1'b0, 1'b0);
        wait_m("after_rst", 8'h02, 1'b0, 1'b0);
        release_m("after_rst");

        run_s(8'h5A, 8'h3C, 1'b0, 1'b0);
        run_s(8'h80, 8'h01, 1'b0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            ref_op(ra, rb, rc, rs, es, eco, eof);
            accept_m(ra, rb, rc, rs);
            wait_m("rand", es, eco, eof);
            release_m("rand");
            run_s(ra, rb, rc, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
